// File: rtl/vedic_mac_unit.sv
// rtl/vedic_mac_unit.sv - 4x4 Vedic multiplier feeding a LEN-beat dot-product accumulator
// Contains the 2x2 Urdhva-Tiryakbhyam cell and the MAC top built from four of them.

module vedic_mul_2_bit (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic cross_hi;
    logic cross_lo;
    logic cross_c;
    logic top;

    assign cross_hi = a_i[1] & b_i[0];
    assign cross_lo = a_i[0] & b_i[1];
    assign cross_c  = cross_hi & cross_lo;
    assign top      = a_i[1] & b_i[1];

    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = cross_hi ^ cross_lo;
    assign p_o[2] = top ^ cross_c;
    assign p_o[3] = top & cross_c;
endmodule

module vedic_mac_unit #(
    parameter int LEN   = 8,
    parameter int ACC_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    localparam int CNT_W = $clog2(LEN) + 1;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t             state_q, state_d;
    logic [7:0]         prod_q;
    logic               pv_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;

    logic [3:0]         p_ll, p_hl, p_lh, p_hh;
    logic [4:0]         p_mid;
    logic [7:0]         prod;
    logic [ACC_W:0]     sum;
    logic               accept;
    logic               result_hs;
    logic               last_beat;

    vedic_mul_2_bit u_ll (.a_i(in_a[1:0]), .b_i(in_b[1:0]), .p_o(p_ll));
    vedic_mul_2_bit u_hl (.a_i(in_a[3:2]), .b_i(in_b[1:0]), .p_o(p_hl));
    vedic_mul_2_bit u_lh (.a_i(in_a[1:0]), .b_i(in_b[3:2]), .p_o(p_lh));
    vedic_mul_2_bit u_hh (.a_i(in_a[3:2]), .b_i(in_b[3:2]), .p_o(p_hh));

    assign p_mid = {1'b0, p_hl} + {1'b0, p_lh};
    assign prod  = {4'b0000, p_ll} + {1'b0, p_mid, 2'b00} + {p_hh, 4'b0000};

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    assign accept    = in_valid & in_ready;
    assign result_hs = out_valid & out_ready;
    assign last_beat = accept && (cnt_q == CNT_W'(LEN - 1));
    assign sum       = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);

    // DRAIN stays until the final registered product has been folded into acc.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (last_beat) state_d = DRAIN;
            DRAIN:   if (!pv_q)     state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (result_hs) begin
            cnt_d = '0;
            acc_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (accept) cnt_d = cnt_q + 1'b1;
            if (pv_q) begin
                acc_d = sum[ACC_W-1:0];
                ovf_d = ovf_q | sum[ACC_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            prod_q  <= '0;
            pv_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pv_q    <= accept;
            if (accept) prod_q <= prod;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
